// File: rtl/step_ex_alu.sv
// Execute-step ALU for the sequencer bus: samples r0/r1 on ena_, writes the result back to r0 and pulses rdy_.
// Define STEP_EX_ALU_MUL_EN to add the iterative shift-add multiplier for op 111.
module step_ex_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena_,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] r0_dout,
    input  logic [WIDTH-1:0] r1_dout,
    output logic [WIDTH-1:0] r0_din,
    output logic             r0_we_,
    output logic             rdy_,
    output logic             c_flag,
    output logic             z_flag
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_ADC = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } op_t;

`ifdef STEP_EX_ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
`else
    typedef enum logic {IDLE, EXEC} state_t;
`endif

    state_t           state;
    op_t              op_q;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_we;
    logic             drive;

    // Evaluated during EXEC from held operands, so ADC sees the carry committed by the previous step.
    always_comb begin
        sum    = '0;
        res    = '0;
        res_c  = c_flag;
        res_we = 1'b1;
        unique case (op_q)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
            end
            OP_SUB: begin
                sum   = {1'b0, a} - {1'b0, b};
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
            end
            OP_AND: begin
                res   = a & b;
                res_c = 1'b0;
            end
            OP_OR: begin
                res   = a | b;
                res_c = 1'b0;
            end
            OP_XOR: begin
                res   = a ^ b;
                res_c = 1'b0;
            end
            OP_ADC: begin
                sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_flag};
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
            end
            OP_SHL: begin
                res   = {a[WIDTH-2:0], 1'b0};
                res_c = a[WIDTH-1];
            end
            OP_MUL: begin
`ifdef STEP_EX_ALU_MUL_EN
                res   = acc[WIDTH-1:0];
                res_c = |acc[2*WIDTH-1:WIDTH];
`else
                res_we = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    assign drive  = (state == EXEC) && res_we;
    assign rdy_   = (state == EXEC) ? 1'b0 : 1'bz;
    assign r0_we_ = drive ? 1'b0 : 1'bz;
    assign r0_din = drive ? res : {WIDTH{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= OP_ADD;
            a      <= '0;
            b      <= '0;
            c_flag <= 1'b0;
            z_flag <= 1'b0;
`ifdef STEP_EX_ALU_MUL_EN
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
`endif
        end else begin
            if (drive) begin
                c_flag <= res_c;
                z_flag <= (res == '0);
            end
            case (state)
                IDLE, EXEC: begin
                    if (!ena_) begin
                        a    <= r0_dout;
                        b    <= r1_dout;
                        op_q <= op_t'(op);
`ifdef STEP_EX_ALU_MUL_EN
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, r0_dout};
                        mplier <= r1_dout;
                        cnt    <= '0;
                        state  <= (op_t'(op) == OP_MUL) ? MUL : EXEC;
`else
                        state <= EXEC;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
`ifdef STEP_EX_ALU_MUL_EN
                // WIDTH shift-add steps, then the write cycle; r0 commits WIDTH+1 edges after sampling.
                MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= EXEC;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
